// File: rtl/if1_fetch_if.sv
// ICache request/response channel between the fetch unit (master) and the
// instruction cache (slave). One request outstanding; response is a 1-cycle strobe.
interface if1_fetch_if #(
    parameter int WORD = 32
);
    logic            icache_req_valid;
    logic            icache_req_ready;
    logic [WORD-1:0] icache_req_addr;
    logic            icache_resp_valid;
    logic [WORD-1:0] icache_resp_data;

    modport master (
        output icache_req_valid,
        output icache_req_addr,
        input  icache_req_ready,
        input  icache_resp_valid,
        input  icache_resp_data
    );

    modport slave (
        input  icache_req_valid,
        input  icache_req_addr,
        output icache_req_ready,
        output icache_resp_valid,
        output icache_resp_data
    );
endinterface

// File: rtl/if1_fetch_unit.sv
// IF1 fetch unit: owns the fetch PC, issues single-outstanding ICache reads and
// feeds {pc, inst, valid} into the IF1/ID register with a one-entry skid buffer.
module if1_fetch_unit #(
    parameter int              WORD   = 32,
    parameter logic [WORD-1:0] PC_RST = 32'h1c00_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_in,
    input  logic               ex_redirect,
    input  logic [WORD-1:0]    ex_target,
    input  logic               pre_redirect,
    input  logic [WORD-1:0]    pre_target,
    if1_fetch_if.master        icache,
    output logic [WORD-1:0]    if_pc_out,
    output logic [WORD-1:0]    if_inst_out,
    output logic               if_valid_out
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t          r_state, w_state_next;
    logic [WORD-1:0] r_fetch_pc, w_fetch_pc_next;
    logic [WORD-1:0] r_out_pc, w_out_pc_next;
    logic [WORD-1:0] r_out_inst, w_out_inst_next;
    logic            r_out_valid, w_out_valid_next;
    // The skid entry is occupied exactly while the FSM sits in HOLD.
    logic [WORD-1:0] r_skid_pc, w_skid_pc_next;
    logic [WORD-1:0] r_skid_inst, w_skid_inst_next;

    logic            w_redirect;
    logic [WORD-1:0] w_target;
    logic            w_consume;
    logic            w_loadable;
    logic            w_req_valid;
    logic            w_handshake;

    assign w_redirect  = ex_redirect | pre_redirect;
    assign w_target    = ex_redirect ? ex_target : pre_target;
    assign w_consume   = r_out_valid & ~stall_in;
    assign w_loadable  = ~r_out_valid | w_consume;
    assign w_req_valid = (r_state == S_REQ) & ~rst;
    assign w_handshake = w_req_valid & icache.icache_req_ready;

    assign icache.icache_req_valid = w_req_valid;
    assign icache.icache_req_addr  = r_fetch_pc;

    assign if_pc_out    = r_out_pc;
    assign if_inst_out  = r_out_inst;
    assign if_valid_out = r_out_valid;

    always_comb begin
        w_state_next     = r_state;
        w_fetch_pc_next  = r_fetch_pc;
        w_out_pc_next    = r_out_pc;
        w_out_inst_next  = r_out_inst;
        w_out_valid_next = r_out_valid;
        w_skid_pc_next   = r_skid_pc;
        w_skid_inst_next = r_skid_inst;

        if (w_consume) begin
            w_out_valid_next = 1'b0;
            w_out_inst_next  = '0;
        end

        case (r_state)
            S_REQ: begin
                if (w_redirect) begin
                    w_fetch_pc_next = w_target;
                end
                if (w_handshake) begin
                    w_state_next = w_redirect ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (icache.icache_resp_valid) begin
                    if (w_redirect) begin
                        w_fetch_pc_next = w_target;
                        w_state_next    = S_REQ;
                    end else if (w_loadable) begin
                        w_out_pc_next    = r_fetch_pc;
                        w_out_inst_next  = icache.icache_resp_data;
                        w_out_valid_next = 1'b1;
                        w_fetch_pc_next  = r_fetch_pc + WORD'(4);
                        w_state_next     = S_REQ;
                    end else begin
                        w_skid_pc_next   = r_fetch_pc;
                        w_skid_inst_next = icache.icache_resp_data;
                        w_fetch_pc_next  = r_fetch_pc + WORD'(4);
                        w_state_next     = S_HOLD;
                    end
                end else if (w_redirect) begin
                    w_fetch_pc_next = w_target;
                    w_state_next    = S_DROP;
                end
            end
            S_DROP: begin
                if (w_redirect) begin
                    w_fetch_pc_next = w_target;
                end
                if (icache.icache_resp_valid) begin
                    w_state_next = S_REQ;
                end
            end
            S_HOLD: begin
                if (w_redirect) begin
                    w_fetch_pc_next = w_target;
                    w_state_next    = S_REQ;
                end else if (w_loadable) begin
                    w_out_pc_next    = r_skid_pc;
                    w_out_inst_next  = r_skid_inst;
                    w_out_valid_next = 1'b1;
                    w_state_next     = S_REQ;
                end
            end
            default: begin
                w_state_next = S_REQ;
            end
        endcase

        // Flush wins over stall: a redirect empties both buffered slots.
        if (w_redirect) begin
            w_out_valid_next = 1'b0;
            w_out_inst_next  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_REQ;
            r_fetch_pc  <= PC_RST;
            r_out_pc    <= PC_RST;
            r_out_inst  <= '0;
            r_out_valid <= 1'b0;
            r_skid_pc   <= '0;
            r_skid_inst <= '0;
        end else begin
            r_state     <= w_state_next;
            r_fetch_pc  <= w_fetch_pc_next;
            r_out_pc    <= w_out_pc_next;
            r_out_inst  <= w_out_inst_next;
            r_out_valid <= w_out_valid_next;
            r_skid_pc   <= w_skid_pc_next;
            r_skid_inst <= w_skid_inst_next;
        end
    end

endmodule

// File: tb/tb_if1_fetch_unit.sv
// Directed per-cycle vector bench for if1_fetch_unit, plus a short free-running
// fetch sequence against a tiny ICache responder.
module tb_if1_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        pre_redirect;
    logic [31:0] pre_target;
    logic [31:0] if_pc_out;
    logic [31:0] if_inst_out;
    logic        if_valid_out;

    if1_fetch_if #(.WORD(32)) icache_bus ();

    if1_fetch_unit #(.WORD(32), .PC_RST(32'h1c00_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_in     (stall_in),
        .ex_redirect  (ex_redirect),
        .ex_target    (ex_target),
        .pre_redirect (pre_redirect),
        .pre_target   (pre_target),
        .icache       (icache_bus),
        .if_pc_out    (if_pc_out),
        .if_inst_out  (if_inst_out),
        .if_valid_out (if_valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        exr;
        logic [31:0] ext;
        logic        prer;
        logic [31:0] pret;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic v(input logic r, input logic st, input logic exr, input logic [31:0] ext,
                     input logic prer, input logic [31:0] pret, input logic rdy, input logic rv,
                     input logic [31:0] rd, input logic e_rqv, input logic [31:0] e_addr,
                     input logic e_ov, input logic [31:0] e_pc, input logic [31:0] e_inst);
        vec_t t;
        t.rst = r; t.stall = st; t.exr = exr; t.ext = ext; t.prer = prer; t.pret = pret;
        t.rdy = rdy; t.rv = rv; t.rd = rd; t.e_rqv = e_rqv; t.e_addr = e_addr;
        t.e_ov = e_ov; t.e_pc = e_pc; t.e_inst = e_inst;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp_v);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        pending;
        logic [31:0] paddr;
        logic [31:0] exp_pc;
        int          got;

        rst = 1'b1; stall_in = 1'b0; ex_redirect = 1'b0; ex_target = '0;
        pre_redirect = 1'b0; pre_target = '0;
        icache_bus.icache_req_ready  = 1'b0;
        icache_bus.icache_resp_valid = 1'b0;
        icache_bus.icache_resp_data  = '0;
        repeat (2) @(posedge clk);

        //  rst st exr ext           prer pret          rdy rv rd            rqv addr          ov pc            inst
        // Plain fetch stream, one instruction every two cycles
        v(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'h1c000000, 0, 32'h1c000000, 32'h0);
        v(0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h1c000000, 0, 32'h1c000000, 32'h0);
        v(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h1111,     0, 32'h1c000000, 0, 32'h1c000000, 32'h0);
        v(0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h1c000004, 1, 32'h1c000000, 32'h1111);
        v(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h2222,     0, 32'h1c000004, 0, 32'h1c000000, 32'h0);
        v(0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h1c000008, 1, 32'h1c000004, 32'h2222);
        v(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h3333,     0, 32'h1c000008, 0, 32'h1c000004, 32'h0);
        v(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h1c00000c, 1, 32'h1c000008, 32'h3333);
        // Reset, then stall for 5 cycles with output full and skid filled
        v(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'h1c00000c, 0, 32'h1c000008, 32'h0);
        v(0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h1c000000, 0, 32'h1c000000, 32'h0);
        v(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h1111,     0, 32'h1c000000, 0, 32'h1c000000, 32'h0);
        v(0, 1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h1c000004, 1, 32'h1c000000, 32'h1111);
        v(0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h2222,     0, 32'h1c000004, 1, 32'h1c000000, 32'h1111);
        v(0, 1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        0, 32'h1c000008, 1, 32'h1c000000, 32'h1111);
        v(0, 1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        0, 32'h1c000008, 1, 32'h1c000000, 32'h1111);
        v(0, 1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        0, 32'h1c000008, 1, 32'h1c000000, 32'h1111);
        v(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'h1c000008, 1, 32'h1c000000, 32'h1111);
        v(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h1c000008, 1, 32'h1c000004, 32'h2222);
        // EX redirect while waiting: stale response dropped
        v(0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h1c000008, 0, 32'h1c000004, 32'h0);
        v(0, 0, 1, 32'h1c000100, 0, 32'h0,        0, 0, 32'h0,        0, 32'h1c000008, 0, 32'h1c000004, 32'h0);
        v(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h3333,     0, 32'h1c000100, 0, 32'h1c000004, 32'h0);
        v(0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h1c000100, 0, 32'h1c000004, 32'h0);
        // Predictor redirect coinciding with the response
        v(0, 0, 0, 32'h0,        1, 32'h1c000180, 0, 1, 32'h4444,     0, 32'h1c000100, 0, 32'h1c000004, 32'h0);
        // EX and predictor together: EX wins
        v(0, 0, 1, 32'h1c000200, 1, 32'h1c000300, 0, 0, 32'h0,        1, 32'h1c000180, 0, 32'h1c000004, 32'h0);
        v(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h1c000200, 0, 32'h1c000004, 32'h0);
        // Redirect on the handshake edge goes through DROP
        v(0, 0, 0, 32'h0,        1, 32'h1c000300, 1, 0, 32'h0,        1, 32'h1c000200, 0, 32'h1c000004, 32'h0);
        v(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h5555,     0, 32'h1c000300, 0, 32'h1c000004, 32'h0);
        v(0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h1c000300, 0, 32'h1c000004, 32'h0);
        v(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h6666,     0, 32'h1c000300, 0, 32'h1c000004, 32'h0);
        // Redirect during stall with output valid and skid full
        v(0, 1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h1c000304, 1, 32'h1c000300, 32'h6666);
        v(0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h7777,     0, 32'h1c000304, 1, 32'h1c000300, 32'h6666);
        v(0, 1, 1, 32'h1c000400, 0, 32'h0,        0, 0, 32'h0,        0, 32'h1c000308, 1, 32'h1c000300, 32'h6666);
        v(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h1c000400, 0, 32'h1c000300, 32'h0);
        v(0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h1c000400, 0, 32'h1c000300, 32'h0);
        v(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h8888,     0, 32'h1c000400, 0, 32'h1c000300, 32'h0);
        v(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h1c000404, 1, 32'h1c000400, 32'h8888);
        // PC wrap from FFFFFFFC
        v(0, 0, 1, 32'hfffffffc, 0, 32'h0,        0, 0, 32'h0,        1, 32'h1c000404, 0, 32'h1c000400, 32'h0);
        v(0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'hfffffffc, 0, 32'h1c000400, 32'h0);
        v(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h9999,     0, 32'hfffffffc, 0, 32'h1c000400, 32'h0);
        v(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h00000000, 1, 32'hfffffffc, 32'h9999);
        // Reset with a request outstanding; late response is ignored
        v(0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h00000000, 0, 32'hfffffffc, 32'h0);
        v(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'h00000000, 0, 32'hfffffffc, 32'h0);
        v(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'haaaa,     1, 32'h1c000000, 0, 32'h1c000000, 32'h0);
        v(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h1c000000, 0, 32'h1c000000, 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst          = vecs[i].rst;
            stall_in     = vecs[i].stall;
            ex_redirect  = vecs[i].exr;
            ex_target    = vecs[i].ext;
            pre_redirect = vecs[i].prer;
            pre_target   = vecs[i].pret;
            icache_bus.icache_req_ready  = vecs[i].rdy;
            icache_bus.icache_resp_valid = vecs[i].rv;
            icache_bus.icache_resp_data  = vecs[i].rd;
            #1;
            $display("vec %0d: req_valid=%0b addr=%08h valid=%0b pc=%08h inst=%08h", i,
                     icache_bus.icache_req_valid, icache_bus.icache_req_addr,
                     if_valid_out, if_pc_out, if_inst_out);
            check($sformatf("vec%0d req_valid", i), {31'b0, icache_bus.icache_req_valid}, {31'b0, vecs[i].e_rqv});
            check($sformatf("vec%0d req_addr", i), icache_bus.icache_req_addr, vecs[i].e_addr);
            check($sformatf("vec%0d if_valid", i), {31'b0, if_valid_out}, {31'b0, vecs[i].e_ov});
            check($sformatf("vec%0d if_pc", i), if_pc_out, vecs[i].e_pc);
            check($sformatf("vec%0d if_inst", i), if_inst_out, vecs[i].e_inst);
        end

        // Free-running stream against a responder that answers one cycle after each handshake
        @(negedge clk);
        rst = 1'b1;
        ex_redirect = 1'b0; pre_redirect = 1'b0; stall_in = 1'b0;
        icache_bus.icache_req_ready  = 1'b0;
        icache_bus.icache_resp_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        icache_bus.icache_req_ready = 1'b1;
        pending = 1'b0;
        paddr   = '0;
        exp_pc  = 32'h1c000000;
        got     = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (if_valid_out) begin
                $display("stream %0d: pc=%08h inst=%08h", got, if_pc_out, if_inst_out);
                check($sformatf("stream%0d pc", got), if_pc_out, exp_pc);
                check($sformatf("stream%0d inst", got), if_inst_out, exp_pc ^ 32'h5a5a_5a5a);
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            icache_bus.icache_resp_valid = pending;
            icache_bus.icache_resp_data  = paddr ^ 32'h5a5a_5a5a;
            #1;
            pending = icache_bus.icache_req_valid & icache_bus.icache_req_ready;
            if (pending) paddr = icache_bus.icache_req_addr;
            @(negedge clk);
        end
        check("stream count", got, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if1_fetch_unit.md
Name: if1_fetch_unit

Overview:
- Producer side of the IF1->ID pipeline register.
- Owns the fetch PC, issues one-outstanding-at-a-time instruction reads to the ICache, and presents {PC, inst, valid} to the IF1/ID register.
- Honours the downstream DCache stall and redirects from EX-stage branch resolution and the pre-decode branch predictor.
- Discards in-flight responses that a redirect has made stale.

Parameters:
PC_RST, 32'h1c00_0000, fetch PC after reset (matches IF1/ID reset PC)
WORD, 32, address/instruction width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall_in  in  1  downstream stall (DCache); output register must hold
ex_redirect  in  1  EX branch mispredict/taken redirect
ex_target  in  WORD  EX redirect PC
pre_redirect  in  1  predictor redirect
pre_target  in  WORD  predictor redirect PC
icache_req_valid  out  1  fetch request valid
icache_req_ready  in  1  ICache accepts request
icache_req_addr  out  WORD  fetch address
icache_resp_valid  in  1  one-cycle response strobe
icache_resp_data  in  WORD  instruction
if_pc_out  out  WORD  PC to IF1/ID
if_inst_out  out  WORD  instruction to IF1/ID
if_valid_out  out  1  output register holds a live instruction

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: fetch_pc=PC_RST, state=REQ, if_valid_out=0, if_pc_out=PC_RST, if_inst_out=0, skid buffer empty. icache_req_valid=0 during the reset cycle.
- Redirect priority: ex_redirect over pre_redirect. redirect = ex_redirect|pre_redirect; target is selected by that priority.
- Output register consumed: at an edge where if_valid_out=1 and stall_in=0.
- Output register loaded: when empty or being consumed that edge.
- Invalid output: if_inst_out=0 whenever if_valid_out=0 (bubble).

States:
- REQ: icache_req_valid=1, icache_req_addr=fetch_pc.
  - Handshake (valid&ready) without redirect -> WAIT.
  - Handshake with redirect -> DROP; fetch_pc<=target.
  - Redirect without handshake -> stay REQ; fetch_pc<=target. Address changes next cycle.
- WAIT: icache_req_valid=0.
  - resp_valid with redirect -> discard data; fetch_pc<=target; -> REQ.
  - resp_valid, no redirect, output loadable -> load {fetch_pc, data}, valid=1; fetch_pc<=fetch_pc+4; -> REQ.
  - resp_valid, no redirect, output not loadable (stalled) -> write skid {fetch_pc, data}; fetch_pc<=fetch_pc+4; -> HOLD.
  - Redirect with no resp_valid -> fetch_pc<=target; -> DROP.
- DROP: icache_req_valid=0; wait for resp_valid, discard it, -> REQ.
  - Further redirects while in DROP update fetch_pc only.
- HOLD: icache_req_valid=0.
  - When output loadable, move skid -> output register; -> REQ.
  - Redirect -> clear skid; fetch_pc<=target; -> REQ.

Redirect and flush:
- Any redirect clears if_valid_out and the skid at that edge, overriding stall_in.
- This mirrors the IF1/ID flush-over-stall rule.

Arithmetic and invariants:
- PC+4 wraps modulo 2^32.
- Targets are used as-is; the low two bits are not checked.
- At most one outstanding request.
- Never more than two buffered instructions (output register + skid).

Reset mid-operation:
- Returns to REQ at PC_RST.
- A response arriving in the first post-reset cycle, before any new handshake, is ignored. Only WAIT accepts data.

Test Plan:
- Reset then ICache ready with 1-cycle response, stall_in=0 -> if_pc_out sequence 1c000000, 1c000004, 1c000008, one instruction every 2 cycles; if_inst_out equals resp data.
- Hold stall_in=1 for 5 cycles after 2 fetches -> output register holds 1c000000 unchanged; skid holds 1c000004; no request issued; release -> 1c000000 consumed, then 1c000004 presented, then request to 1c000008.
- ex_redirect to 1c000100 while in WAIT -> response for 1c000008 discarded (if_valid_out stays 0); next request address 1c000100.
- ex_redirect (1c000200) and pre_redirect (1c000300) same cycle -> fetch_pc=1c000200.
- Redirect during stall_in=1 with valid output and full skid -> if_valid_out=0 and skid empty next cycle; request to target issued.
- fetch_pc=FFFFFFFC fetch completes -> next icache_req_addr=00000000.
